// File: rtl/sq_pkg.sv
// Shared constants and helpers for the pipelined squarer / sum-of-squares block.
package sq_pkg;

  localparam int DEF_IW     = 13;
  localparam int DEF_STAGES = 2;
  localparam int DEF_ACCW   = 40;
  localparam int DEF_LAT    = DEF_STAGES + 1;

  typedef enum logic {
    MODE_SQ  = 1'b0,
    MODE_ACC = 1'b1
  } sq_mode_e;

  function automatic int sq_width(input int iw);
    return 2 * iw;
  endfunction

  function automatic int sq_lat(input int stages);
    return stages + 1;
  endfunction

endpackage

// File: rtl/sq_acc_pipe_if.sv
// Stream handshake bundle between the statistics path and the squarer block.
interface sq_acc_pipe_if #(
  parameter int IW   = sq_pkg::DEF_IW,
  parameter int ACCW = sq_pkg::DEF_ACCW
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_data;
  logic            in_last;
  logic            acc_mode;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_data;
  logic            out_last;
  logic            ovf;

  modport master (
    output in_valid, in_data, in_last, acc_mode, out_ready,
    input  in_ready, out_valid, out_data, out_last, ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, acc_mode, out_ready,
    output in_ready, out_valid, out_data, out_last, ovf
  );
endinterface

// File: rtl/sq_core.sv
// Pipelined unsigned squarer with a shared stall enable and valid/last/mode sidebands.
module sq_core
  import sq_pkg::*;
#(
  parameter  int IW     = DEF_IW,
  parameter  int STAGES = DEF_STAGES,
  localparam int SQW    = sq_width(IW)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           valid_i,
  input  logic           last_i,
  input  logic           mode_i,
  input  logic [IW-1:0]  data_i,
  output logic           valid_o,
  output logic           last_o,
  output logic           mode_o,
  output logic [SQW-1:0] sq_o
);

  localparam int LW = IW / 2;
  localparam int HW = IW - LW;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("sq_core: STAGES must be 1..4");
  end
  if (IW < 2) begin : g_bad_iw
    $error("sq_core: IW must be at least 2");
  end

  logic [HW-1:0]   hiIn;
  logic [LW-1:0]   loIn;
  logic [2*HW-1:0] hhIn;
  logic [IW-1:0]   hlIn;
  logic [2*LW-1:0] llIn;

  // Operand split into halves: x^2 = hi^2*2^(2L) + 2*hi*lo*2^L + lo^2
  assign hiIn = data_i[IW-1:LW];
  assign loIn = data_i[LW-1:0];
  assign hhIn = {{HW{1'b0}}, hiIn} * {{HW{1'b0}}, hiIn};
  assign hlIn = {{LW{1'b0}}, hiIn} * {{HW{1'b0}}, loIn};
  assign llIn = {{LW{1'b0}}, loIn} * {{LW{1'b0}}, loIn};

  function automatic logic [SQW-1:0] combine(input logic [2*HW-1:0] hh,
                                             input logic [IW-1:0]   hl,
                                             input logic [2*LW-1:0] ll);
    return (SQW'(hh) << (2 * LW)) + (SQW'(hl) << (LW + 1)) + SQW'(ll);
  endfunction

  logic [STAGES-1:0] valid_q, last_q, mode_q;
  logic [STAGES:0]   validChain, lastChain, modeChain;

  assign validChain = {valid_q, valid_i};
  assign lastChain  = {last_q, last_i};
  assign modeChain  = {mode_q, mode_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      last_q  <= '0;
      mode_q  <= '0;
    end else if (en_i) begin
      valid_q <= validChain[STAGES-1:0];
      last_q  <= lastChain[STAGES-1:0];
      mode_q  <= modeChain[STAGES-1:0];
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign last_o  = last_q[STAGES-1];
  assign mode_o  = mode_q[STAGES-1];

  if (STAGES == 1) begin : g_one
    logic [SQW-1:0] sq_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sq_q <= '0;
      end else if (en_i) begin
        sq_q <= combine(hhIn, hlIn, llIn);
      end
    end

    assign sq_o = sq_q;
  end else begin : g_multi
    // First stage holds partial products, second sums them, the rest only delay
    logic [2*HW-1:0] hh_q;
    logic [IW-1:0]   hl_q;
    logic [2*LW-1:0] ll_q;
    logic [SQW-1:0]  sqPipe_q [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hh_q <= '0;
        hl_q <= '0;
        ll_q <= '0;
        for (int i = 0; i < STAGES - 1; i++) sqPipe_q[i] <= '0;
      end else if (en_i) begin
        hh_q        <= hhIn;
        hl_q        <= hlIn;
        ll_q        <= llIn;
        sqPipe_q[0] <= combine(hh_q, hl_q, ll_q);
        for (int i = 1; i < STAGES - 1; i++) sqPipe_q[i] <= sqPipe_q[i-1];
      end
    end

    assign sq_o = sqPipe_q[STAGES-2];
  end

endmodule

// File: rtl/sq_acc_pipe.sv
// Squarer stream with per-frame saturating sum-of-squares and a single output register.
module sq_acc_pipe
  import sq_pkg::*;
#(
  parameter int IW     = DEF_IW,
  parameter int STAGES = DEF_STAGES,
  parameter int ACCW   = DEF_ACCW
) (
  input logic         clk,
  input logic         rst_n,
  sq_acc_pipe_if.slave bus
);

  localparam int SQW = sq_width(IW);
  localparam logic [ACCW-1:0] ACC_MAX = '1;

  if (ACCW < 2 * IW) begin : g_bad_accw
    $error("sq_acc_pipe: ACCW must be at least 2*IW");
  end

  logic            en, accept, beatMode;
  logic            coreValid, coreLast, coreMode;
  logic [SQW-1:0]  coreSq;
  logic [ACCW-1:0] sqExt, sumSat;
  logic [ACCW:0]   sumWide;
  logic            sumOvf;

  logic            frameActive_q, frameActive_d, frameMode_q, frameMode_d;
  logic [ACCW-1:0] acc_q, acc_d, outData_q, outData_d;
  logic            accOvf_q, accOvf_d;
  logic            outValid_q, outValid_d, outLast_q, outLast_d, outOvf_q, outOvf_d;

  assign en           = !outValid_q || bus.out_ready;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

  // Mode is taken from the first beat of a frame and frozen until its last beat
  assign beatMode = frameActive_q ? frameMode_q : bus.acc_mode;

  sq_core #(.IW(IW), .STAGES(STAGES)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .valid_i (accept),
    .last_i  (bus.in_last),
    .mode_i  (beatMode),
    .data_i  (bus.in_data),
    .valid_o (coreValid),
    .last_o  (coreLast),
    .mode_o  (coreMode),
    .sq_o    (coreSq)
  );

  assign sqExt   = ACCW'(coreSq);
  assign sumWide = {1'b0, acc_q} + {1'b0, sqExt};
  assign sumOvf  = sumWide[ACCW];
  assign sumSat  = sumOvf ? ACC_MAX : sumWide[ACCW-1:0];

  always_comb begin
    frameActive_d = frameActive_q;
    frameMode_d   = frameMode_q;
    if (accept) begin
      frameActive_d = !bus.in_last;
      frameMode_d   = beatMode;
    end
  end

  // Accumulator and sticky overflow clear in the cycle the frame result is loaded
  always_comb begin
    acc_d      = acc_q;
    accOvf_d   = accOvf_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outOvf_d   = outOvf_q;
    if (en) begin
      outValid_d = 1'b0;
      if (coreValid) begin
        if (coreMode == MODE_SQ) begin
          outValid_d = 1'b1;
          outData_d  = sqExt;
          outLast_d  = coreLast;
          outOvf_d   = 1'b0;
        end else if (coreLast) begin
          outValid_d = 1'b1;
          outData_d  = sumSat;
          outLast_d  = 1'b1;
          outOvf_d   = accOvf_q || sumOvf;
          acc_d      = '0;
          accOvf_d   = 1'b0;
        end else begin
          acc_d    = sumSat;
          accOvf_d = accOvf_q || sumOvf;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameActive_q <= 1'b0;
      frameMode_q   <= 1'b0;
      acc_q         <= '0;
      accOvf_q      <= 1'b0;
      outValid_q    <= 1'b0;
      outData_q     <= '0;
      outLast_q     <= 1'b0;
      outOvf_q      <= 1'b0;
    end else begin
      frameActive_q <= frameActive_d;
      frameMode_q   <= frameMode_d;
      acc_q         <= acc_d;
      accOvf_q      <= accOvf_d;
      outValid_q    <= outValid_d;
      outData_q     <= outData_d;
      outLast_q     <= outLast_d;
      outOvf_q      <= outOvf_d;
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.ovf       = outOvf_q;

endmodule
